// File: rtl/rgbc_window_averager_if.sv
// Sample and averaged-result bundle between the TCS34725 reader, the window
// averager and its consumers.
interface rgbc_window_averager_if #(
    parameter int LOG2_N = 2
);
    // data_valid and avg_valid are single-cycle strobes with no backpressure:
    // the payload fields are meaningful only in the cycle the strobe is high.
    logic [15:0]     red;
    logic [15:0]     green;
    logic [15:0]     blue;
    logic [15:0]     clear;
    logic            data_valid;
    logic            flush;

    logic [15:0]     avg_red;
    logic [15:0]     avg_green;
    logic [15:0]     avg_blue;
    logic [15:0]     avg_clear;
    logic            avg_valid;
    logic            avg_saturated;
    logic            stale;
    logic [LOG2_N:0] fill_count;

    modport master (
        output red, green, blue, clear, data_valid, flush,
        input  avg_red, avg_green, avg_blue, avg_clear,
        input  avg_valid, avg_saturated, stale, fill_count
    );

    modport slave (
        input  red, green, blue, clear, data_valid, flush,
        output avg_red, avg_green, avg_blue, avg_clear,
        output avg_valid, avg_saturated, stale, fill_count
    );
endinterface

// File: rtl/rgbc_window_averager.sv
// Block averager for RGBC samples: non-overlapping windows of 2^LOG2_N samples,
// per-window saturation flag and a sticky stale flag on sensor silence.
module rgbc_window_averager #(
    parameter int          LOG2_N         = 2,
    parameter logic [15:0] SAT_LEVEL      = 16'hFFFF,
    parameter logic [23:0] TIMEOUT_CYCLES = 24'd1_200_000
) (
    input logic                    clk_i,
    input logic                    rst_i,
    rgbc_window_averager_if.slave  bus
);

    localparam int              AW        = 16 + LOG2_N;
    localparam logic [LOG2_N:0] LAST_FILL = (LOG2_N + 1)'((1 << LOG2_N) - 1);
    localparam logic [LOG2_N:0] FILL_ONE  = (LOG2_N + 1)'(1);
    localparam logic [23:0]     IDLE_MAX  = TIMEOUT_CYCLES - 24'd1;

    // Channel order in all arrays: 0 red, 1 green, 2 blue, 3 clear.
    logic [15:0]     sample [4];
    logic [AW-1:0]   sum    [4];
    logic [AW-1:0]   acc_q  [4];
    logic [AW-1:0]   acc_d  [4];
    logic [15:0]     avg_q  [4];
    logic [15:0]     avg_d  [4];

    logic [LOG2_N:0] fill_q, fill_d;
    logic            sat_seen_q, sat_seen_d;
    logic            avg_sat_q, avg_sat_d;
    logic            avg_valid_q, avg_valid_d;
    logic            stale_q, stale_d;
    logic [23:0]     idle_q, idle_d;

    logic            accept;
    logic            complete;
    logic            sample_sat;
    logic            timeout_hit;
    logic            discard;

    always_comb begin
        sample[0] = bus.red;
        sample[1] = bus.green;
        sample[2] = bus.blue;
        sample[3] = bus.clear;

        accept      = bus.data_valid & ~bus.flush;
        complete    = accept & (fill_q == LAST_FILL);
        sample_sat  = (bus.clear >= SAT_LEVEL);
        // Silence for the full timeout; a strobe in this cycle always wins.
        timeout_hit = ~bus.data_valid & (idle_q == IDLE_MAX);
        discard     = bus.flush | timeout_hit;

        for (int ch = 0; ch < 4; ch++) begin
            sum[ch] = acc_q[ch] + AW'(sample[ch]);
        end
    end

    always_comb begin
        for (int ch = 0; ch < 4; ch++) begin
            acc_d[ch] = acc_q[ch];
            avg_d[ch] = avg_q[ch];
        end
        fill_d      = fill_q;
        sat_seen_d  = sat_seen_q;
        avg_sat_d   = avg_sat_q;
        avg_valid_d = 1'b0;

        if (discard) begin
            for (int ch = 0; ch < 4; ch++) begin
                acc_d[ch] = '0;
            end
            fill_d     = '0;
            sat_seen_d = 1'b0;
        end else if (complete) begin
            // Truncating divide: drop the LOG2_N low bits of the full sum.
            for (int ch = 0; ch < 4; ch++) begin
                acc_d[ch] = '0;
                avg_d[ch] = sum[ch][AW-1:LOG2_N];
            end
            fill_d      = '0;
            sat_seen_d  = 1'b0;
            avg_sat_d   = sat_seen_q | sample_sat;
            avg_valid_d = 1'b1;
        end else if (accept) begin
            for (int ch = 0; ch < 4; ch++) begin
                acc_d[ch] = sum[ch];
            end
            fill_d     = fill_q + FILL_ONE;
            sat_seen_d = sat_seen_q | sample_sat;
        end
    end

    always_comb begin
        idle_d  = idle_q;
        stale_d = stale_q;
        if (bus.data_valid) begin
            idle_d  = '0;
            stale_d = 1'b0;
        end else begin
            if (idle_q != IDLE_MAX) begin
                idle_d = idle_q + 24'd1;
            end
            if (timeout_hit) begin
                stale_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            for (int ch = 0; ch < 4; ch++) begin
                acc_q[ch] <= '0;
                avg_q[ch] <= '0;
            end
            fill_q      <= '0;
            sat_seen_q  <= 1'b0;
            avg_sat_q   <= 1'b0;
            avg_valid_q <= 1'b0;
            stale_q     <= 1'b0;
            idle_q      <= '0;
        end else begin
            for (int ch = 0; ch < 4; ch++) begin
                acc_q[ch] <= acc_d[ch];
                avg_q[ch] <= avg_d[ch];
            end
            fill_q      <= fill_d;
            sat_seen_q  <= sat_seen_d;
            avg_sat_q   <= avg_sat_d;
            avg_valid_q <= avg_valid_d;
            stale_q     <= stale_d;
            idle_q      <= idle_d;
        end
    end

    assign bus.avg_red       = avg_q[0];
    assign bus.avg_green     = avg_q[1];
    assign bus.avg_blue      = avg_q[2];
    assign bus.avg_clear     = avg_q[3];
    assign bus.avg_valid     = avg_valid_q;
    assign bus.avg_saturated = avg_sat_q;
    assign bus.stale         = stale_q;
    assign bus.fill_count    = fill_q;

endmodule

// File: tb/tb_rgbc_window_averager.sv
// Directed bench for rgbc_window_averager: table of per-cycle vectors plus
// hand sequences for timeout, reset mid-window and the LOG2_N=0 build.
module tb_rgbc_window_averager;

    logic clk;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    logic [63:0] exp_q[$];

    rgbc_window_averager_if #(.LOG2_N(2)) bus ();
    rgbc_window_averager_if #(.LOG2_N(0)) bus0 ();

    rgbc_window_averager #(
        .LOG2_N(2), .SAT_LEVEL(16'hFFFF), .TIMEOUT_CYCLES(24'd10)
    ) dut (
        .clk_i(clk), .rst_i(rst_n), .bus(bus)
    );

    rgbc_window_averager #(
        .LOG2_N(0), .SAT_LEVEL(16'hFFFF), .TIMEOUT_CYCLES(24'd1_200_000)
    ) dut0 (
        .clk_i(clk), .rst_i(rst_n), .bus(bus0)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        logic        dv, fl;
        logic [15:0] r, g, b, c;
        logic        ev;
        logic [15:0] er, eg, eb, ec;
        logic        es;
        logic [2:0]  ef;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic dv, logic fl,
                                logic [15:0] r, logic [15:0] g, logic [15:0] b, logic [15:0] c,
                                logic ev, logic [15:0] er, logic [15:0] eg, logic [15:0] eb,
                                logic [15:0] ec, logic es, logic [2:0] ef);
        vec_t v;
        v.dv = dv; v.fl = fl; v.r = r; v.g = g; v.b = b; v.c = c;
        v.ev = ev; v.er = er; v.eg = eg; v.eb = eb; v.ec = ec; v.es = es; v.ef = ef;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(logic dv, logic fl, logic [15:0] r, logic [15:0] g,
                         logic [15:0] b, logic [15:0] c);
        bus.data_valid = dv;
        bus.flush      = fl;
        bus.red        = r;
        bus.green      = g;
        bus.blue       = b;
        bus.clear      = c;
    endtask

    // scoreboard: every avg_valid pulse must match the oldest expected window
    always @(negedge clk) begin
        if (rst_n && bus.avg_valid) begin
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL sb_unexpected: got %0h expected no window",
                         {bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear});
            end else begin
                logic [63:0] e;
                e = exp_q.pop_front();
                if ({bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear} !== e) begin
                    errors++;
                    $display("FAIL sb_window: got %0h expected %0h",
                             {bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear}, e);
                end
            end
        end
    end

    initial begin
        vec_t v;
        rst_n = 1'b0;
        drive(0, 0, 0, 0, 0, 0);
        bus0.data_valid = 1'b0;
        bus0.flush      = 1'b0;
        bus0.red        = '0;
        bus0.green      = '0;
        bus0.blue       = '0;
        bus0.clear      = '0;

        // Basic window
        vecs.push_back(mk(1,0, 100,4,0,1000, 0, 0,0,0,0, 0, 1));
        vecs.push_back(mk(1,0, 101,4,0,1000, 0, 0,0,0,0, 0, 2));
        vecs.push_back(mk(1,0, 102,4,0,1000, 0, 0,0,0,0, 0, 3));
        vecs.push_back(mk(1,0, 103,4,0,1000, 1, 101,4,0,1000, 0, 0));
        vecs.push_back(mk(0,0, 0,0,0,0,      0, 101,4,0,1000, 0, 0));
        // Max values, back-to-back
        vecs.push_back(mk(1,0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 0, 101,4,0,1000, 0, 1));
        vecs.push_back(mk(1,0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 0, 101,4,0,1000, 0, 2));
        vecs.push_back(mk(1,0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 0, 101,4,0,1000, 0, 3));
        vecs.push_back(mk(1,0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF,
                          1, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1, 0));
        // Saturated only on the completing sample; clear sum 65541 -> 16385
        vecs.push_back(mk(1,0, 10,0,7,1,        0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1, 1));
        vecs.push_back(mk(1,0, 20,0,7,2,        0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1, 2));
        vecs.push_back(mk(1,0, 30,0,7,3,        0, 16'hFFFF,16'hFFFF,16'hFFFF,16'hFFFF, 1, 3));
        vecs.push_back(mk(1,0, 40,0,7,16'hFFFF, 1, 25,0,7,16385, 1, 0));
        vecs.push_back(mk(1,0, 10,10,10,10,     0, 25,0,7,16385, 1, 1));
        vecs.push_back(mk(1,0, 10,10,10,10,     0, 25,0,7,16385, 1, 2));
        vecs.push_back(mk(1,0, 10,10,10,10,     0, 25,0,7,16385, 1, 3));
        vecs.push_back(mk(1,0, 10,10,10,10,     1, 10,10,10,10, 0, 0));
        vecs.push_back(mk(0,0, 0,0,0,0,         0, 10,10,10,10, 0, 0));
        // Flush mid-window drops the coincident sample
        vecs.push_back(mk(1,0, 50,0,0,0,  0, 10,10,10,10, 0, 1));
        vecs.push_back(mk(1,0, 50,0,0,0,  0, 10,10,10,10, 0, 2));
        vecs.push_back(mk(1,1, 999,0,0,0, 0, 10,10,10,10, 0, 0));
        vecs.push_back(mk(1,0, 8,0,0,0,   0, 10,10,10,10, 0, 1));
        vecs.push_back(mk(1,0, 8,0,0,0,   0, 10,10,10,10, 0, 2));
        vecs.push_back(mk(1,0, 8,0,0,0,   0, 10,10,10,10, 0, 3));
        vecs.push_back(mk(1,0, 8,0,0,0,   1, 8,0,0,0, 0, 0));
        vecs.push_back(mk(0,0, 0,0,0,0,   0, 8,0,0,0, 0, 0));

        step();
        step();
        check("rst_avg_valid", bus.avg_valid, 0);
        check("rst_avg_all", {bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear}, 0);
        check("rst_sat", bus.avg_saturated, 0);
        check("rst_stale", bus.stale, 0);
        check("rst_fill", bus.fill_count, 0);
        rst_n = 1'b1;

        foreach (vecs[i]) begin
            v = vecs[i];
            drive(v.dv, v.fl, v.r, v.g, v.b, v.c);
            step();
            if (v.ev) exp_q.push_back({v.er, v.eg, v.eb, v.ec});
            check($sformatf("v%0d_valid", i), bus.avg_valid, v.ev);
            check($sformatf("v%0d_red", i),   bus.avg_red,   v.er);
            check($sformatf("v%0d_green", i), bus.avg_green, v.eg);
            check($sformatf("v%0d_blue", i),  bus.avg_blue,  v.eb);
            check($sformatf("v%0d_clear", i), bus.avg_clear, v.ec);
            check($sformatf("v%0d_sat", i),   bus.avg_saturated, v.es);
            check($sformatf("v%0d_fill", i),  bus.fill_count, v.ef);
            check($sformatf("v%0d_stale", i), bus.stale, 0);
        end

        // Timeout: stale rises exactly 10 edges after the last strobe
        drive(1, 0, 5, 0, 0, 0);
        step();
        check("to_fill_first", bus.fill_count, 1);
        drive(0, 0, 0, 0, 0, 0);
        for (int k = 1; k <= 10; k++) begin
            step();
            check($sformatf("to_stale_k%0d", k), bus.stale, (k == 10) ? 1 : 0);
        end
        check("to_fill_discard", bus.fill_count, 0);
        step();
        check("to_stale_sticky", bus.stale, 1);
        drive(1, 0, 7, 3, 0, 0);
        step();
        check("to_stale_clear", bus.stale, 0);
        check("to_fill_new", bus.fill_count, 1);
        check("to_avg_hold", {bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear},
              {16'd8, 16'd0, 16'd0, 16'd0});
        check("to_valid", bus.avg_valid, 0);

        // Reset mid-window (three samples accepted, reset beats a strobe)
        drive(1, 0, 7, 3, 0, 0);
        step();
        step();
        check("rm_fill_pre", bus.fill_count, 3);
        rst_n = 1'b0;
        drive(1, 0, 9, 9, 9, 9);
        step();
        rst_n = 1'b1;
        check("rm_avg_all", {bus.avg_red, bus.avg_green, bus.avg_blue, bus.avg_clear}, 0);
        check("rm_fill", bus.fill_count, 0);
        check("rm_valid", bus.avg_valid, 0);
        check("rm_stale", bus.stale, 0);
        for (int k = 1; k <= 4; k++) begin
            drive(1, 0, 0, 0, 20, 0);
            step();
            if (k == 4) exp_q.push_back({16'd0, 16'd0, 16'd20, 16'd0});
            check($sformatf("rm_fill_k%0d", k), bus.fill_count, k % 4);
        end
        check("rm_valid_win", bus.avg_valid, 1);
        check("rm_avg_blue", bus.avg_blue, 20);
        check("rm_avg_red", bus.avg_red, 0);
        check("rm_sat", bus.avg_saturated, 0);
        drive(0, 0, 0, 0, 0, 0);
        step();
        check("rm_valid_drop", bus.avg_valid, 0);

        // LOG2_N = 0: one-cycle delayed copy on every strobe
        bus0.data_valid = 1'b1;
        bus0.red = 16'd1234; bus0.green = 16'd1; bus0.blue = 16'd2; bus0.clear = 16'hFFFF;
        step();
        check("n0_valid1", bus0.avg_valid, 1);
        check("n0_copy1", {bus0.avg_red, bus0.avg_green, bus0.avg_blue, bus0.avg_clear},
              {16'd1234, 16'd1, 16'd2, 16'hFFFF});
        check("n0_sat1", bus0.avg_saturated, 1);
        check("n0_fill1", bus0.fill_count, 0);
        bus0.red = 16'd42; bus0.green = 16'd0; bus0.blue = 16'd0; bus0.clear = 16'd5;
        step();
        check("n0_valid2", bus0.avg_valid, 1);
        check("n0_red2", bus0.avg_red, 42);
        check("n0_clear2", bus0.avg_clear, 5);
        check("n0_sat2", bus0.avg_saturated, 0);
        bus0.data_valid = 1'b0;
        step();
        check("n0_valid3", bus0.avg_valid, 0);
        check("n0_red_hold", bus0.avg_red, 42);

        step();
        check("sb_drained", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rgbc_window_averager.md
Name: rgbc_window_averager

Overview:
Sits directly downstream of the TCS34725 reader. Consumes its 16-bit red/green/blue/clear samples, qualified by the one-cycle data_valid strobe, and averages them over non-overlapping blocks of 2^LOG2_N samples. Emits averaged channels with a one-cycle avg_valid strobe, a per-window saturation flag, and a sticky stale flag when the sensor stops producing samples. Feeds colour classification and any display or logging logic.

Parameters:
LOG2_N, 2, log2 of samples per window; legal range 0..6; window size N = 2^LOG2_N.
SAT_LEVEL, 16'hFFFF, a sample is saturated when its clear input is >= this value.
TIMEOUT_CYCLES, 24'd1_200_000, clk cycles without data_valid before stale asserts (100 ms at 12 MHz); legal range 2..2^24-1.

Ports:
clk  in  1  system clock, 12 MHz.
rst  in  1  reset; synchronous to clk, active-low.
red  in  16  raw red sample.
green  in  16  raw green sample.
blue  in  16  raw blue sample.
clear  in  16  raw clear sample.
data_valid  in  1  one-cycle strobe; the sample inputs are valid in that cycle only.
flush  in  1  synchronous discard of the partial window.
avg_red  out  16  averaged red; holds until the next avg_valid.
avg_green  out  16  averaged green; holds until the next avg_valid.
avg_blue  out  16  averaged blue; holds until the next avg_valid.
avg_clear  out  16  averaged clear; holds until the next avg_valid.
avg_valid  out  1  one-cycle strobe; the avg_* outputs and avg_saturated are updated in this cycle.
avg_saturated  out  1  1 if any sample in the completed window was saturated.
stale  out  1  sticky; no data_valid for TIMEOUT_CYCLES cycles.
fill_count  out  LOG2_N+1  number of samples accumulated in the current window (0..N-1).

Behaviour:
- Reset (rst low at posedge clk). All avg_* outputs = 0, avg_valid = 0, avg_saturated = 0, stale = 0, fill_count = 0. Accumulators, saturation-seen bit and idle counter are cleared. Reset takes priority over every other input; a partial window in progress is discarded.
- Accumulators. One per channel, width 16+LOG2_N bits, so they cannot overflow. A sample is accepted on any cycle with data_valid=1 and flush=0.
- Accept, window not complete (fill_count < N-1): add each channel to its accumulator; fill_count += 1; sat_seen |= (clear >= SAT_LEVEL).
- Accept, completing sample (fill_count == N-1):
  - Compute the full sums including this sample.
  - Next cycle: avg_x = sum_x >> LOG2_N (truncating, no rounding); avg_saturated = sat_seen | this sample's saturation; avg_valid = 1.
  - Accumulators, sat_seen and fill_count all return to 0 at the same edge.
  - Latency: one clk from the completing data_valid to avg_valid.
- LOG2_N = 0: every accepted sample completes a window; the outputs are a one-cycle-delayed copy of the input.
- avg_valid is high for exactly one cycle per window. Back-to-back data_valid on consecutive cycles is supported with no sample loss.
- flush = 1: accumulators, sat_seen and fill_count are cleared at the next edge. A data_valid in the same cycle is dropped (flush has priority). avg_* outputs and stale are unaffected.
- Idle counter (24-bit):
  - Cleared to 0 in any cycle with data_valid=1, whether accepted or dropped by flush.
  - Otherwise increments and saturates at TIMEOUT_CYCLES-1.
  - When it equals TIMEOUT_CYCLES-1 and data_valid=0, stale goes to 1 at that edge. stale therefore rises exactly TIMEOUT_CYCLES edges after the last data_valid cycle.
  - On the same edge stale rises, the partial window is discarded (same effect as flush).
- stale clears at the edge following the next data_valid. That sample is accepted normally as sample 1 of a new window (unless flush is also high).
- Outputs are registered only; no combinational input-to-output path.

Test Plan:
1. Basic window (LOG2_N=2): after reset, four data_valid pulses with red=100,101,102,103, green=4, blue=0, clear=1000 -> one cycle after the 4th strobe, avg_valid=1 for 1 cycle, avg_red=101, avg_green=4, avg_blue=0, avg_clear=1000, avg_saturated=0; fill_count sequence 0,1,2,3,0.
2. Max values and saturation (LOG2_N=2, back-to-back strobes on consecutive cycles): four samples all FFFF, SAT_LEVEL=FFFF -> avg_* = FFFF, avg_saturated=1. Next window of clears 1,2,3,FFFF -> avg_saturated=1. Following window of all-10 samples -> avg_saturated=0.
3. Flush mid-window: two samples of red=50, then flush together with a third data_valid (red=999) -> fill_count=0, sample dropped. Four further samples of red=8 -> avg_red=8, single avg_valid.
4. Timeout (TIMEOUT_CYCLES=10): one sample, then no strobes -> stale rises exactly 10 edges after the strobe, fill_count=0. Next data_valid -> stale=0 one cycle later, fill_count=1, avg outputs unchanged.
5. Reset mid-window: three samples accepted, then rst low for one cycle -> all outputs 0. Four samples of blue=20 -> avg_blue=20.
6. LOG2_N=0 build: strobe with red=1234 -> next cycle avg_red=1234 with avg_valid on every strobe.
